// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
// Optional feature macro used by this slice: LSU_MISALIGN_TRAP_EN.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LOAD_BYTE   = 3'b000;
    localparam logic [2:0] LOAD_HALF   = 3'b001;
    localparam logic [2:0] LOAD_WORD   = 3'b010;
    localparam logic [2:0] LOAD_BYTE_U = 3'b100;
    localparam logic [2:0] LOAD_HALF_U = 3'b101;
    localparam logic [2:0] STORE_BYTE  = 3'b000;
    localparam logic [2:0] STORE_HALF  = 3'b001;
    localparam logic [2:0] STORE_WORD  = 3'b010;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// Request handshake: a request transfers on a posedge where i_ReqValid and o_ReqReady are both 1.
interface load_store_unit_if;
    logic        i_ReqValid;
    logic        o_ReqReady;
    logic        i_ReqWrite;
    logic [2:0]  i_ReqFunct3;
    logic [31:0] i_ReqAddress;
    logic [31:0] i_ReqData;
    logic        o_RespValid;
    logic [31:0] o_RespData;
    logic        o_RespMisaligned;
    logic        o_RespInvalidMode;
    logic        o_MemReadEnable;
    logic        o_MemWriteEnable;
    logic [31:0] o_MemAddress;
    logic [31:0] o_MemDataOut;
    logic [2:0]  o_MemMode;
    logic [31:0] i_MemDataIn;

    modport slave (
        input  i_ReqValid, i_ReqWrite, i_ReqFunct3, i_ReqAddress, i_ReqData, i_MemDataIn,
        output o_ReqReady, o_RespValid, o_RespData, o_RespMisaligned, o_RespInvalidMode,
               o_MemReadEnable, o_MemWriteEnable, o_MemAddress, o_MemDataOut, o_MemMode
    );

    modport master (
        output i_ReqValid, i_ReqWrite, i_ReqFunct3, i_ReqAddress, i_ReqData, i_MemDataIn,
        input  o_ReqReady, o_RespValid, o_RespData, o_RespMisaligned, o_RespInvalidMode,
               o_MemReadEnable, o_MemWriteEnable, o_MemAddress, o_MemDataOut, o_MemMode
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte/half extraction, store merging and fault classification.
// LSU_MISALIGN_TRAP_EN turns unaligned half/word accesses into a fault instead of aligning down.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_Word,
    input  logic [31:0] i_Data,
    input  logic [1:0]  i_Offset,
    input  logic [2:0]  i_Funct3,
    input  logic        i_Write,
    output logic [31:0] o_LoadData,
    output logic [31:0] o_WriteWord,
    output logic        o_Misaligned,
    output logic        o_InvalidMode
);
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = i_Word[{i_Offset, 3'b000} +: 8];
        halfSel = i_Offset[1] ? i_Word[31:16] : i_Word[15:0];

        o_LoadData = '0;
        case (i_Funct3)
            LOAD_BYTE:   o_LoadData = {{24{byteSel[7]}}, byteSel};
            LOAD_HALF:   o_LoadData = {{16{halfSel[15]}}, halfSel};
            LOAD_WORD:   o_LoadData = i_Word;
            LOAD_BYTE_U: o_LoadData = {24'd0, byteSel};
            LOAD_HALF_U: o_LoadData = {16'd0, halfSel};
            default:     o_LoadData = '0;
        endcase

        // Sub-word stores patch only the addressed lane of the word just read.
        o_WriteWord = i_Word;
        case (i_Funct3)
            STORE_BYTE: o_WriteWord[{i_Offset, 3'b000} +: 8]      = i_Data[7:0];
            STORE_HALF: o_WriteWord[{i_Offset[1], 4'b0000} +: 16] = i_Data[15:0];
            STORE_WORD: o_WriteWord = i_Data;
            default:    o_WriteWord = i_Word;
        endcase

        if (i_Write)
            o_InvalidMode = !(i_Funct3 inside {STORE_BYTE, STORE_HALF, STORE_WORD});
        else
            o_InvalidMode = !(i_Funct3 inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_U, LOAD_HALF_U});

`ifdef LSU_MISALIGN_TRAP_EN
        // funct3[1:0] = 01 is a half access, 10 a word access, for every legal code.
        o_Misaligned = !o_InvalidMode &&
                       (((i_Funct3[1:0] == 2'b01) && i_Offset[0]) ||
                        ((i_Funct3[1:0] == 2'b10) && (i_Offset != 2'b00)));
`else
        o_Misaligned = 1'b0;
`endif
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, full-word memory accesses, sub-word read-modify-write.
// Optional misalignment trapping is selected by LSU_MISALIGN_TRAP_EN (see lsu_align).
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic              i_Clock,
    input  logic              i_Reset,
    load_store_unit_if.slave  bus,
    output lsu_state_t        o_State
);
    lsu_state_t  state, nextState;
    logic        reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddress;
    logic [31:0] reqData;
    logic [31:0] memWord;
    logic        faultMisaligned;
    logic        faultInvalid;

    logic        accept;
    logic        curWrite;
    logic [2:0]  curFunct3;
    logic [1:0]  curOffset;
    logic [31:0] curData;
    logic [31:0] loadData;
    logic [31:0] writeWord;
    logic        alignMisaligned;
    logic        alignInvalid;

    // Classify the incoming request while idle; afterwards work from the latched copy.
    assign accept    = (state == IDLE) && bus.i_ReqValid;
    assign curWrite  = (state == IDLE) ? bus.i_ReqWrite         : reqWrite;
    assign curFunct3 = (state == IDLE) ? bus.i_ReqFunct3        : reqFunct3;
    assign curOffset = (state == IDLE) ? bus.i_ReqAddress[1:0]  : reqAddress[1:0];
    assign curData   = (state == IDLE) ? bus.i_ReqData          : reqData;

    lsu_align u_align (
        .i_Word        (memWord),
        .i_Data        (curData),
        .i_Offset      (curOffset),
        .i_Funct3      (curFunct3),
        .i_Write       (curWrite),
        .o_LoadData    (loadData),
        .o_WriteWord   (writeWord),
        .o_Misaligned  (alignMisaligned),
        .o_InvalidMode (alignInvalid)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) state <= IDLE;
        else         state <= nextState;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            reqWrite        <= 1'b0;
            reqFunct3       <= '0;
            reqAddress      <= '0;
            reqData         <= '0;
            memWord         <= '0;
            faultMisaligned <= 1'b0;
            faultInvalid    <= 1'b0;
        end else begin
            if (accept) begin
                reqWrite        <= bus.i_ReqWrite;
                reqFunct3       <= bus.i_ReqFunct3;
                reqAddress      <= bus.i_ReqAddress;
                reqData         <= bus.i_ReqData;
                faultMisaligned <= alignMisaligned;
                faultInvalid    <= alignInvalid;
            end
            if (state == READ) memWord <= bus.i_MemDataIn;
        end
    end

    assign bus.o_MemMode = LOAD_WORD;
    assign o_State       = state;

    always_comb begin
        nextState             = state;
        bus.o_ReqReady        = 1'b0;
        bus.o_RespValid       = 1'b0;
        bus.o_RespData        = '0;
        bus.o_RespMisaligned  = 1'b0;
        bus.o_RespInvalidMode = 1'b0;
        bus.o_MemReadEnable   = 1'b0;
        bus.o_MemWriteEnable  = 1'b0;
        bus.o_MemAddress      = '0;
        bus.o_MemDataOut      = '0;
        case (state)
            IDLE: begin
                bus.o_ReqReady = 1'b1;
                if (bus.i_ReqValid) begin
                    if (alignInvalid || alignMisaligned)
                        nextState = RESP;
                    else if (bus.i_ReqWrite && (bus.i_ReqFunct3 == STORE_WORD))
                        nextState = WRITE;
                    else
                        nextState = READ;
                end
            end
            READ: begin
                bus.o_MemReadEnable = 1'b1;
                bus.o_MemAddress    = {reqAddress[31:2], 2'b00};
                nextState           = reqWrite ? WRITE : RESP;
            end
            WRITE: begin
                // A reset landing on the write cycle must not disturb memory.
                bus.o_MemWriteEnable = !i_Reset;
                bus.o_MemAddress     = {reqAddress[31:2], 2'b00};
                bus.o_MemDataOut     = writeWord;
                nextState            = RESP;
            end
            RESP: begin
                bus.o_RespValid       = 1'b1;
                bus.o_RespMisaligned  = faultMisaligned;
                bus.o_RespInvalidMode = faultInvalid;
                if (!reqWrite && !faultMisaligned && !faultInvalid)
                    bus.o_RespData = loadData;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end
endmodule
